// File: rtl/cpu_sequencer.sv
// MU0 control sequencer: instruction register, FETCH/EXEC1/EXEC2 phase machine,
// branch resolution, STP halt, single-step support and saturating activity counters.
module cpu_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step_mode,
    input  logic              step,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              acc_neg,
    input  logic              acc_zero,
    output logic              FETCH,
    output logic              EXEC1,
    output logic              EXEC2,
    output logic [3:0]        OP,
    output logic [ADDR_W-1:0] ADDR,
    output logic              IR_LOAD,
    output logic              BR_TAKE,
    output logic              HALTED,
    output logic              BUSY,
    output logic              ILLEGAL,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count
);

    // state    | meaning
    // ST_IDLE  | waiting for run or step
    // ST_FETCH | IR captures mem_q on the exit edge
    // ST_EXEC1 | first execute phase; branch condition resolved here
    // ST_EXEC2 | second execute phase, LDA only
    // ST_HALT  | stopped by STP; only run resumes
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC1,
        ST_EXEC2,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JMI = 4'h5;
    localparam logic [3:0] OP_JEQ = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;
    localparam logic [3:0] OP_ILL = 4'hB;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state;
    state_t            state_next;
    state_t            next_instr;
    logic [DATA_W-1:0] ir;

    assign OP      = ir[DATA_W-1 -: 4];
    assign ADDR    = ir[ADDR_W-1:0];
    assign IR_LOAD = FETCH;
    assign BR_TAKE = EXEC1 & ((OP == OP_JMP) | ((OP == OP_JMI) & acc_neg) |
                              ((OP == OP_JEQ) & acc_zero));

    always_comb begin
        state_next = state;
        next_instr = step_mode ? ST_IDLE : ST_FETCH;
        case (state)
            ST_IDLE:  if (run || step) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_EXEC1;
            ST_EXEC1: begin
                if (OP == OP_LDA)      state_next = ST_EXEC2;
                else if (OP == OP_STP) state_next = ST_HALT;
                else                   state_next = next_instr;
            end
            ST_EXEC2: state_next = next_instr;
            ST_HALT:  if (run) state_next = ST_FETCH;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Strobes are flopped from state_next so they track state exactly, glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ir          <= '0;
            FETCH       <= 1'b0;
            EXEC1       <= 1'b0;
            EXEC2       <= 1'b0;
            HALTED      <= 1'b0;
            BUSY        <= 1'b0;
            ILLEGAL     <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            state  <= state_next;
            FETCH  <= (state_next == ST_FETCH);
            EXEC1  <= (state_next == ST_EXEC1);
            EXEC2  <= (state_next == ST_EXEC2);
            HALTED <= (state_next == ST_HALT);
            BUSY   <= (state_next == ST_FETCH) || (state_next == ST_EXEC1) ||
                      (state_next == ST_EXEC2);
            if (state == ST_FETCH) ir <= mem_q;
            if (state == ST_EXEC1) begin
                if (OP >= OP_ILL) ILLEGAL <= 1'b1;
                if (instr_count != CNT_MAX) instr_count <= instr_count + 1'b1;
            end
            if (BUSY && (cycle_count != CNT_MAX)) cycle_count <= cycle_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer; a narrow-counter second
// instance shares the stimulus to exercise counter saturation.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [15:0] mem_q = 16'h0000;
    logic        acc_neg = 1'b0;
    logic        acc_zero = 1'b0;

    logic        FETCH, EXEC1, EXEC2, IR_LOAD, BR_TAKE, HALTED, BUSY, ILLEGAL;
    logic [3:0]  OP;
    logic [11:0] ADDR;
    logic [15:0] cycle_count, instr_count;

    logic        s_fetch, s_exec1, s_exec2, s_ir_load, s_br_take, s_halted, s_busy, s_illegal;
    logic [3:0]  s_op;
    logic [11:0] s_addr;
    logic [3:0]  s_cycle_count, s_instr_count;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [4:0] P_I  = 5'b00000;
    localparam logic [4:0] P_F  = 5'b10001;
    localparam logic [4:0] P_E1 = 5'b01001;
    localparam logic [4:0] P_E2 = 5'b00101;
    localparam logic [4:0] P_H  = 5'b00010;

    wire [4:0] ph = {FETCH, EXEC1, EXEC2, HALTED, BUSY};

    cpu_sequencer #(.DATA_W(16), .ADDR_W(12), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step),
        .mem_q(mem_q), .acc_neg(acc_neg), .acc_zero(acc_zero),
        .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .OP(OP), .ADDR(ADDR),
        .IR_LOAD(IR_LOAD), .BR_TAKE(BR_TAKE), .HALTED(HALTED), .BUSY(BUSY),
        .ILLEGAL(ILLEGAL), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    cpu_sequencer #(.DATA_W(16), .ADDR_W(12), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step),
        .mem_q(mem_q), .acc_neg(acc_neg), .acc_zero(acc_zero),
        .FETCH(s_fetch), .EXEC1(s_exec1), .EXEC2(s_exec2), .OP(s_op), .ADDR(s_addr),
        .IR_LOAD(s_ir_load), .BR_TAKE(s_br_take), .HALTED(s_halted), .BUSY(s_busy),
        .ILLEGAL(s_illegal), .cycle_count(s_cycle_count), .instr_count(s_instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0; step_mode = 1'b0;
        acc_neg = 1'b0; acc_zero = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        mem_q = 16'h2005;
        do_reset();
        n_cmp++; if (ph !== P_I) begin n_err++; $display("FAIL reset_phase: got %b expected %b", ph, P_I); end
        n_cmp++; if ({OP, ADDR} !== 16'h0000) begin n_err++; $display("FAIL reset_ir: got %h expected 0000", {OP, ADDR}); end
        n_cmp++; if ({cycle_count, instr_count} !== 32'h0) begin n_err++; $display("FAIL reset_counts: got %h expected 0", {cycle_count, instr_count}); end
        n_cmp++; if ({ILLEGAL, BR_TAKE, IR_LOAD} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {ILLEGAL, BR_TAKE, IR_LOAD}); end
        tick();
        n_cmp++; if (ph !== P_I) begin n_err++; $display("FAIL idle_hold: got %b expected %b", ph, P_I); end
    endtask

    task automatic test_add();
        do_reset();
        mem_q = 16'h2005; run = 1'b1;
        tick(); run = 1'b0;
        n_cmp++; if ({ph, IR_LOAD} !== {P_F, 1'b1}) begin n_err++; $display("FAIL add_fetch: got %b expected %b", {ph, IR_LOAD}, {P_F, 1'b1}); end
        tick();
        n_cmp++; if (ph !== P_E1) begin n_err++; $display("FAIL add_exec1: got %b expected %b", ph, P_E1); end
        n_cmp++; if ({OP, ADDR} !== 16'h2005) begin n_err++; $display("FAIL add_opaddr: got %h expected 2005", {OP, ADDR}); end
        n_cmp++; if ({cycle_count, instr_count} !== {16'd1, 16'd0}) begin n_err++; $display("FAIL add_cnt_e1: got %h expected 00010000", {cycle_count, instr_count}); end
        tick();
        n_cmp++; if (ph !== P_F) begin n_err++; $display("FAIL add_refetch: got %b expected %b", ph, P_F); end
        n_cmp++; if ({cycle_count, instr_count} !== {16'd2, 16'd1}) begin n_err++; $display("FAIL add_cnt: got %h expected 00020001", {cycle_count, instr_count}); end
    endtask

    task automatic test_lda();
        do_reset();
        mem_q = 16'h0010; run = 1'b1;
        tick(); run = 1'b0;
        tick();
        n_cmp++; if ({ph, OP, ADDR} !== {P_E1, 16'h0010}) begin n_err++; $display("FAIL lda_exec1: got %h expected %h", {ph, OP, ADDR}, {P_E1, 16'h0010}); end
        tick();
        n_cmp++; if ({ph, OP} !== {P_E2, 4'h0}) begin n_err++; $display("FAIL lda_exec2: got %b expected %b", {ph, OP}, {P_E2, 4'h0}); end
        tick();
        n_cmp++; if (ph !== P_F) begin n_err++; $display("FAIL lda_refetch: got %b expected %b", ph, P_F); end
        n_cmp++; if ({cycle_count, instr_count} !== {16'd3, 16'd1}) begin n_err++; $display("FAIL lda_cnt: got %h expected 00030001", {cycle_count, instr_count}); end
        tick();
        n_cmp++; if (ph !== P_E1) begin n_err++; $display("FAIL lda_next_exec1: got %b expected %b", ph, P_E1); end
    endtask

    task automatic test_branch();
        logic [15:0] vec_mem [7] = '{16'h5020, 16'h5020, 16'h6020, 16'h6020, 16'h4020, 16'h4020, 16'h2020};
        logic        vec_neg [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        vec_zero[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        vec_br  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        run = 1'b1;
        tick(); run = 1'b0;
        for (int i = 0; i < 7; i++) begin
            mem_q = vec_mem[i]; acc_neg = vec_neg[i]; acc_zero = vec_zero[i];
            #1;
            n_cmp++; if (BR_TAKE !== 1'b0) begin n_err++; $display("FAIL br_fetch[%0d]: got %b expected 0", i, BR_TAKE); end
            tick();
            n_cmp++; if ({EXEC1, BR_TAKE} !== {1'b1, vec_br[i]}) begin n_err++; $display("FAIL br_exec1[%0d]: got %b expected %b", i, {EXEC1, BR_TAKE}, {1'b1, vec_br[i]}); end
            tick();
        end
    endtask

    task automatic test_stp();
        do_reset();
        mem_q = 16'h7000; run = 1'b1;
        tick(); run = 1'b0;
        tick();
        n_cmp++; if ({ph, OP} !== {P_E1, 4'h7}) begin n_err++; $display("FAIL stp_exec1: got %b expected %b", {ph, OP}, {P_E1, 4'h7}); end
        tick();
        n_cmp++; if (ph !== P_H) begin n_err++; $display("FAIL stp_halt: got %b expected %b", ph, P_H); end
        n_cmp++; if ({cycle_count, instr_count} !== {16'd2, 16'd1}) begin n_err++; $display("FAIL stp_cnt: got %h expected 00020001", {cycle_count, instr_count}); end
        step = 1'b1; tick(); step = 1'b0; tick(); tick();
        n_cmp++; if (ph !== P_H) begin n_err++; $display("FAIL stp_step_ignored: got %b expected %b", ph, P_H); end
        n_cmp++; if ({cycle_count, instr_count} !== {16'd2, 16'd1}) begin n_err++; $display("FAIL stp_frozen: got %h expected 00020001", {cycle_count, instr_count}); end
        mem_q = 16'h2005; run = 1'b1;
        tick(); run = 1'b0;
        n_cmp++; if (ph !== P_F) begin n_err++; $display("FAIL stp_resume: got %b expected %b", ph, P_F); end
    endtask

    task automatic test_step_mode();
        do_reset();
        step_mode = 1'b1; mem_q = 16'h2005; run = 1'b1;
        tick(); run = 1'b0;
        step = 1'b1;
        tick();
        tick(); step = 1'b0;
        n_cmp++; if ({ph, instr_count} !== {P_I, 16'd1}) begin n_err++; $display("FAIL step_first: got %h expected %h", {ph, instr_count}, {P_I, 16'd1}); end
        tick(); tick();
        n_cmp++; if (ph !== P_I) begin n_err++; $display("FAIL step_idle_hold: got %b expected %b", ph, P_I); end
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1;
            tick();
            n_cmp++; if (ph !== P_F) begin n_err++; $display("FAIL step_pulse_fetch[%0d]: got %b expected %b", k, ph, P_F); end
            tick(); step = 1'b0;
            tick();
            n_cmp++; if ({ph, instr_count} !== {P_I, 16'(1 + k)}) begin n_err++; $display("FAIL step_pulse[%0d]: got %h expected %h", k, {ph, instr_count}, {P_I, 16'(1 + k)}); end
        end
        run = 1'b1; step = 1'b1;
        tick(); run = 1'b0; step = 1'b0;
        tick(); tick();
        n_cmp++; if ({ph, instr_count, cycle_count} !== {P_I, 16'd5, 16'd10}) begin n_err++; $display("FAIL step_run_both: got %h expected %h", {ph, instr_count, cycle_count}, {P_I, 16'd5, 16'd10}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_q = 16'h0010; run = 1'b1;
        tick(); run = 1'b0;
        tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        n_cmp++; if ({ph, OP, ADDR, cycle_count, instr_count} !== 53'h0) begin n_err++; $display("FAIL rst_mid: got %h expected 0", {ph, OP, ADDR, cycle_count, instr_count}); end
        tick();
        n_cmp++; if (ph !== P_I) begin n_err++; $display("FAIL rst_mid_no_exec2: got %b expected %b", ph, P_I); end
    endtask

    task automatic test_illegal();
        do_reset();
        mem_q = 16'hA000; run = 1'b1;
        tick(); run = 1'b0;
        tick(); tick();
        n_cmp++; if ({ph, ILLEGAL} !== {P_F, 1'b0}) begin n_err++; $display("FAIL ill_legal_a: got %b expected %b", {ph, ILLEGAL}, {P_F, 1'b0}); end
        mem_q = 16'hC123;
        tick();
        n_cmp++; if ({ph, OP, ILLEGAL} !== {P_E1, 4'hC, 1'b0}) begin n_err++; $display("FAIL ill_exec1: got %b expected %b", {ph, OP, ILLEGAL}, {P_E1, 4'hC, 1'b0}); end
        mem_q = 16'h2005;
        tick();
        n_cmp++; if ({ph, ILLEGAL} !== {P_F, 1'b1}) begin n_err++; $display("FAIL ill_set: got %b expected %b", {ph, ILLEGAL}, {P_F, 1'b1}); end
        tick(); tick(); tick();
        n_cmp++; if (ILLEGAL !== 1'b1) begin n_err++; $display("FAIL ill_sticky: got %b expected 1", ILLEGAL); end
        do_reset();
        n_cmp++; if (ILLEGAL !== 1'b0) begin n_err++; $display("FAIL ill_clear: got %b expected 0", ILLEGAL); end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_q = 16'h2005; run = 1'b1;
        tick(); run = 1'b0;
        for (int k = 2; k <= 50; k++) begin
            tick();
            if (k == 16) begin
                n_cmp++; if ({s_cycle_count, s_instr_count} !== {4'd15, 4'd7}) begin n_err++; $display("FAIL sat_reach: got %h expected f7", {s_cycle_count, s_instr_count}); end
            end
            if (k == 17) begin
                n_cmp++; if ({s_cycle_count, s_instr_count} !== {4'd15, 4'd8}) begin n_err++; $display("FAIL sat_cycle_hold: got %h expected f8", {s_cycle_count, s_instr_count}); end
            end
            if (k == 40) begin
                n_cmp++; if ({cycle_count, instr_count} !== {16'd39, 16'd19}) begin n_err++; $display("FAIL wide_cnt: got %h expected %h", {cycle_count, instr_count}, {16'd39, 16'd19}); end
            end
        end
        n_cmp++; if ({s_cycle_count, s_instr_count} !== 8'hFF) begin n_err++; $display("FAIL sat_both: got %h expected ff", {s_cycle_count, s_instr_count}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lda();
        test_branch();
        test_stp();
        test_step_mode();
        test_reset_mid();
        test_illegal();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
